// File: rtl/layers_frame_arbiter.sv
// layers_frame_arbiter: frame-granular round-robin merge of NUM_LAYERS byte streams.
// Define LAYERS_FRAME_HEADER_EN to prefix every output frame with a layer-ID header byte.
module layers_frame_arbiter #(
   parameter int NUM_LAYERS = 3
) (
   input  logic                    clk_core,
   input  logic                    clk_core_resn,
   input  logic [8*NUM_LAYERS-1:0] s_axis_tdata,
   input  logic [8*NUM_LAYERS-1:0] s_axis_tdest,
   input  logic [NUM_LAYERS-1:0]   s_axis_tlast,
   input  logic [NUM_LAYERS-1:0]   s_axis_tvalid,
   output logic [NUM_LAYERS-1:0]   s_axis_tready,
   output logic [7:0]              m_axis_tdata,
   output logic [7:0]              m_axis_tdest,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   input  logic [NUM_LAYERS-1:0]   cfg_layer_mask,
   output logic                    status_busy,
   output logic [31:0]             stat_frame_count
);
   localparam int GW = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1;
   typedef enum logic [1:0] {
      IDLE,
      DATA
`ifdef LAYERS_FRAME_HEADER_EN
      , HEADER
`endif
   } state_t;
   state_t state;
   logic [GW-1:0] grant;
   logic [GW-1:0] last_grant;
   logic [GW-1:0] pick;
   logic [7:0] cur_dest;
   logic [NUM_LAYERS-1:0] cand;
   logic found;
   logic m_free;
   logic beat;
   assign cand = s_axis_tvalid & ~cfg_layer_mask;
   assign m_free = !m_axis_tvalid || m_axis_tready;
   assign beat = state == DATA && s_axis_tvalid[grant] && m_free;
   assign status_busy = state != IDLE;
   // scanning from the far end lets the candidate nearest last_grant+1 win
   always_comb begin
      found = 1'b0;
      pick = '0;
      for (int k = NUM_LAYERS; k >= 1; k--) begin
         if (cand[(int'(last_grant) + k) % NUM_LAYERS]) begin
            found = 1'b1;
            pick = GW'((int'(last_grant) + k) % NUM_LAYERS);
         end
      end
   end
   always_comb begin
      s_axis_tready = '0;
      s_axis_tready[grant] = state == DATA && m_free;
   end
   always_ff @(posedge clk_core) begin
      if (!clk_core_resn) begin
         state <= IDLE;
         grant <= '0;
         last_grant <= GW'(NUM_LAYERS - 1);
         cur_dest <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata <= '0;
         m_axis_tdest <= '0;
         m_axis_tlast <= 1'b0;
         stat_frame_count <= '0;
      end else begin
         if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            if (m_axis_tlast)
               stat_frame_count <= stat_frame_count + 32'd1;
         end
         case (state)
            IDLE: begin
               if (found) begin
                  grant <= pick;
                  last_grant <= pick;
                  cur_dest <= s_axis_tdest[8*int'(pick) +: 8];
`ifdef LAYERS_FRAME_HEADER_EN
                  state <= HEADER;
`else
                  state <= DATA;
`endif
               end
            end
`ifdef LAYERS_FRAME_HEADER_EN
            HEADER: begin
               if (m_free) begin
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata <= cur_dest;
                  m_axis_tdest <= cur_dest;
                  m_axis_tlast <= 1'b0;
                  state <= DATA;
               end
            end
`endif
            DATA: begin
               if (beat) begin
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata <= s_axis_tdata[8*int'(grant) +: 8];
                  m_axis_tdest <= cur_dest;
                  m_axis_tlast <= s_axis_tlast[grant];
                  if (s_axis_tlast[grant])
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_layers_frame_arbiter.sv
// tb_layers_frame_arbiter: randomized scoreboard bench for layers_frame_arbiter.
module tb_layers_frame_arbiter;
   localparam int N = 3;
`ifdef LAYERS_FRAME_HEADER_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif
   logic clk_core = 1'b0;
   logic clk_core_resn = 1'b0;
   logic [8*N-1:0] s_axis_tdata = '0;
   logic [8*N-1:0] s_axis_tdest = '0;
   logic [N-1:0] s_axis_tlast = '0;
   logic [N-1:0] s_axis_tvalid = '0;
   logic [N-1:0] cfg_layer_mask = '0;
   logic m_axis_tready = 1'b1;
   logic [N-1:0] s_axis_tready;
   logic [7:0] m_axis_tdata;
   logic [7:0] m_axis_tdest;
   logic m_axis_tlast;
   logic m_axis_tvalid;
   logic status_busy;
   logic [31:0] stat_frame_count;
   logic [8:0] lq [N][$];
   logic [8:0] mq [N][$];
   logic [16:0] sb [$];
   int cons [N];
   bit [N-1:0] sof = '1;
   bit gaps = 1'b0;
   bit rnd_ready = 1'b0;
   bit mask_chk = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;
   int mdl_last = N - 1;
   logic [31:0] mdl_count = '0;
   bit [N-1:0] p_in;
   bit p_hs;
   bit p_stall;
   logic [16:0] p_beat;

   layers_frame_arbiter #(.NUM_LAYERS(N)) dut (
      .clk_core(clk_core),
      .clk_core_resn(clk_core_resn),
      .s_axis_tdata(s_axis_tdata),
      .s_axis_tdest(s_axis_tdest),
      .s_axis_tlast(s_axis_tlast),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tdest(m_axis_tdest),
      .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .cfg_layer_mask(cfg_layer_mask),
      .status_busy(status_busy),
      .stat_frame_count(stat_frame_count)
   );

   always #5 clk_core = ~clk_core;

   function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endfunction

   // reference: frames leave in round-robin order over unmasked layers with pending frames
   function automatic void predict(input logic [N-1:0] msk);
      logic [8:0] b;
      bit any;
      do begin
         any = 1'b0;
         for (int k = 1; k <= N && !any; k++) begin
            int l;
            l = (mdl_last + k) % N;
            if (!msk[l] && mq[l].size() > 0) begin
               any = 1'b1;
               mdl_last = l;
               mdl_count++;
               if (HDR)
                  sb.push_back({8'(l), 8'(l), 1'b0});
               do begin
                  b = mq[l].pop_front();
                  sb.push_back({8'(l), b[7:0], b[8]});
               end while (!b[8]);
            end
         end
      end while (any);
   endfunction

   task automatic load(input int l, input int len, input int base);
      logic [7:0] d;
      for (int i = 0; i < len; i++) begin
         d = base < 0 ? 8'($urandom) : 8'(base + i);
         lq[l].push_back({i == len - 1, d});
         mq[l].push_back({i == len - 1, d});
      end
   endtask

   task automatic step();
      @(negedge clk_core);
      #2;
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && sb.size() > 0; i++)
         step();
      chk("drain_left", 64'(sb.size()), 64'd0);
      repeat (2) step();
   endtask

   task automatic wait_cons(input int l, input int target);
      for (int i = 0; i < 500 && cons[l] < target; i++)
         step();
      chk("wait_cons", 64'(cons[l] >= target), 64'd1);
   endtask

   task automatic resync();
      sb.delete();
      for (int l = 0; l < N; l++)
         mq[l] = lq[l];
      sof = '1;
      mdl_last = N - 1;
      mdl_count = '0;
   endtask

   task automatic do_reset();
      clk_core_resn = 1'b0;
      step();
      clk_core_resn = 1'b1;
      resync();
   endtask

   always @(posedge clk_core) begin
      p_in <= s_axis_tvalid & s_axis_tready & {N{clk_core_resn}};
      p_hs <= m_axis_tvalid & m_axis_tready & clk_core_resn;
      p_stall <= m_axis_tvalid & !m_axis_tready & clk_core_resn;
      p_beat <= {m_axis_tdest, m_axis_tdata, m_axis_tlast};
   end

   // upstream driver: one queue of {last,data} per layer, gaps only inside frames
   initial begin
      logic [8:0] b;
      forever begin
         @(negedge clk_core);
         #1;
         for (int l = 0; l < N; l++) begin
            if (p_in[l] && lq[l].size() > 0) begin
               b = lq[l].pop_front();
               sof[l] = b[8];
               cons[l]++;
            end
            s_axis_tdest[8*l +: 8] = 8'(l);
            s_axis_tvalid[l] = lq[l].size() > 0 && (sof[l] || !gaps || $urandom_range(3) != 0);
            if (lq[l].size() > 0) begin
               s_axis_tdata[8*l +: 8] = lq[l][0][7:0];
               s_axis_tlast[l] = lq[l][0][8];
            end
         end
         m_axis_tready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
      end
   end

   initial begin
      forever begin
         @(negedge clk_core);
         if (p_hs) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL beat_unexpected: got %h expected none", p_beat);
            end else
               chk("beat", 64'(p_beat), 64'(sb.pop_front()));
         end
         if (p_stall)
            chk("hold", 64'({m_axis_tvalid, m_axis_tdest, m_axis_tdata, m_axis_tlast}), 64'({1'b1, p_beat}));
         if (mask_chk)
            chk("masked_ready", 64'(s_axis_tready[1]), 64'd0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      step();
      step();
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
      chk("rst_tdest", 64'(m_axis_tdest), 64'd0);
      chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
      chk("rst_busy", 64'(status_busy), 64'd0);
      chk("rst_sready", 64'(s_axis_tready), 64'd0);
      chk("rst_count", 64'(stat_frame_count), 64'd0);
      clk_core_resn = 1'b1;
      load(1, 5, 'hA1);
      predict('0);
      drain();
      chk("count_single", 64'(stat_frame_count), 64'(mdl_count));
      do_reset();
      for (int f = 0; f < 2; f++)
         for (int l = 0; l < N; l++)
            load(l, 2, -1);
      predict('0);
      drain();
      chk("count_fair", 64'(stat_frame_count), 64'(mdl_count));
      rnd_ready = 1'b1;
      gaps = 1'b1;
      load(0, 8, -1);
      for (int f = 0; f < 10; f++)
         load(int'($urandom_range(N - 1)), int'($urandom_range(8, 1)), -1);
      predict('0);
      drain();
      rnd_ready = 1'b0;
      gaps = 1'b0;
      chk("count_bp", 64'(stat_frame_count), 64'(mdl_count));
      do_reset();
      cfg_layer_mask = 3'b010;
      mask_chk = 1'b1;
      load(0, 4, -1);
      load(1, 4, -1);
      load(2, 6, -1);
      predict(3'b010);
      wait_cons(2, cons[2] + 1);
      cfg_layer_mask = '0;
      mask_chk = 1'b0;
      predict('0);
      drain();
      chk("count_mask", 64'(stat_frame_count), 64'(mdl_count));
      cfg_layer_mask = 3'b101;
      load(1, 6, -1);
      load(0, 2, -1);
      load(2, 2, -1);
      predict(3'b101);
      wait_cons(1, cons[1] + 3);
      clk_core_resn = 1'b0;
      step();
      chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("midrst_busy", 64'(status_busy), 64'd0);
      chk("midrst_sready", 64'(s_axis_tready), 64'd0);
      clk_core_resn = 1'b1;
      cfg_layer_mask = '0;
      resync();
      predict('0);
      drain();
      chk("count_midrst", 64'(stat_frame_count), 64'(mdl_count));
      force dut.stat_frame_count = 32'hFFFF_FFFF;
      #1;
      release dut.stat_frame_count;
      mdl_count = 32'hFFFF_FFFF;
      load(2, 3, -1);
      predict('0);
      drain();
      chk("count_wrap", 64'(stat_frame_count), 64'(mdl_count));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
